// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and helpers for the synchronous FIFO slice.
//   FIFO_N    default data word width in bits
//   FIFO_M    default depth in entries (power of 2, >= 2)
//   ptr_width pointer width for a given depth (clog2, never below 1)
// Optional feature macro used by this slice: SYNC_FIFO_ERR_FLAGS_EN
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int FIFO_N = 8;
    localparam int FIFO_M = 4;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_if
// Handshake/data bundle between a producer/consumer and the FIFO.
//   wr_en, data_in       write request and write data   (master -> slave)
//   rd_en                read request                   (master -> slave)
//   data_out             registered read data           (slave -> master)
//   status_full          count == M                     (slave -> master)
//   status_empty         count == 0                     (slave -> master)
//   half_full            count >= M/2                   (slave -> master)
//   overflow, underflow  sticky error flags, only when SYNC_FIFO_ERR_FLAGS_EN
//                        is defined                     (slave -> master)
// -----------------------------------------------------------------------------
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int N = FIFO_N
);

    logic         wr_en;
    logic         rd_en;
    logic [N-1:0] data_in;
    logic [N-1:0] data_out;
    logic         status_full;
    logic         status_empty;
    logic         half_full;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic         overflow;
    logic         underflow;

    modport master (
        output wr_en, rd_en, data_in,
        input  data_out, status_full, status_empty, half_full, overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, data_in,
        output data_out, status_full, status_empty, half_full, overflow, underflow
    );
`else
    modport master (
        output wr_en, rd_en, data_in,
        input  data_out, status_full, status_empty, half_full
    );

    modport slave (
        input  wr_en, rd_en, data_in,
        output data_out, status_full, status_empty, half_full
    );
`endif

endinterface

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// M x N register array with one write port and one registered read port.
//   clk      rising-edge clock
//   rst_n    asynchronous reset, active-high; clears only the read register
//   we_i     write enable; wdata_i stored at waddr_i
//   waddr_i  write address
//   wdata_i  write data
//   re_i     read enable; mem[raddr_i] loaded into rdata_o
//   raddr_i  read address
//   rdata_o  registered read data; holds when re_i is low
// -----------------------------------------------------------------------------
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int N  = FIFO_N,
    parameter int M  = FIFO_M,
    parameter int PW = ptr_width(M)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [N-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [PW-1:0] raddr_i,
    output logic [N-1:0]  rdata_o
);

    logic [N-1:0] mem_q [M];
    logic [N-1:0] rdata_q;

    // NOTE: storage has no reset; only the control state and the read register
    // need a known value, and leaving the array unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // NOTE: non-blocking assignment here means a read and a write to the same
    // slot in one cycle return the old word, which is what a full FIFO doing a
    // simultaneous read+write relies on.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock synchronous FIFO, N-bit words, M entries, registered read data.
//   clk    rising-edge clock, the only clock
//   rst_n  asynchronous reset, active-high (asserted = 1) despite its name
//   bus    sync_fifo_if.slave: wr_en, rd_en, data_in in; data_out,
//          status_full, status_empty, half_full out
// Optional feature: define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow
// (dropped write) and underflow (ignored read) outputs on the interface.
// -----------------------------------------------------------------------------
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int N = FIFO_N,
    parameter int M = FIFO_M
) (
    input  logic      clk,
    input  logic      rst_n,
    sync_fifo_if.slave bus
);

    localparam int PW = ptr_width(M);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(M);
    localparam logic [CW-1:0] HALF_CNT = CW'(M / 2);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty;
    logic          do_wr, do_rd;
    logic [N-1:0]  rdata;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // NOTE: every variable gets its hold value first so no path through the
    // block leaves one unassigned and infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // A read frees the head slot this same edge, so a full FIFO may still
        // accept a write when it is also being read.
        do_rd = bus.rd_en && !empty;
        do_wr = bus.wr_en && (!full || bus.rd_en);

        // Pointers are exactly log2(M) bits, so the increment wraps M-1 -> 0.
        if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);

        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    sync_fifo_mem #(
        .N  (N),
        .M  (M),
        .PW (PW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (do_wr),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_in),
        .re_i    (do_rd),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign bus.data_out     = rdata;
    assign bus.status_full  = full;
    assign bus.status_empty = empty;
    assign bus.half_full    = (count_q >= HALF_CNT);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (bus.wr_en && full && !bus.rd_en);
        underflow_d = underflow_q | (bus.rd_en && empty);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Self-checking bench for sync_fifo (N=8, M=4). A queue-based model tracks the
// expected contents, read data and flags; a compare process checks the DUT
// against it every falling edge, and the directed sequence adds literal
// expectations. Honours SYNC_FIFO_ERR_FLAGS_EN when defined.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int N = 8;
    localparam int M = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   cmp_en = 1'b0;

    int checks = 0;
    int errors = 0;

    sync_fifo_if #(.N(N)) bus ();

    sync_fifo #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_q[$];
    logic [N-1:0] m_dout;
    logic         m_ovf, m_unf;

    always @(posedge clk or posedge rst_n) begin : model
        bit rd_ok, wr_ok;
        if (rst_n) begin
            m_q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            rd_ok = bus.rd_en && (m_q.size() != 0);
            wr_ok = bus.wr_en && ((m_q.size() < M) || bus.rd_en);
            if (bus.wr_en && !wr_ok)            m_ovf = 1'b1;
            if (bus.rd_en && m_q.size() == 0)   m_unf = 1'b1;
            if (rd_ok) m_dout = m_q.pop_front();
            if (wr_ok) m_q.push_back(bus.data_in);
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst_n) begin
            check("cmp_data_out", 32'(bus.data_out), 32'(m_dout));
            check("cmp_empty", 32'(bus.status_empty), 32'(m_q.size() == 0));
            check("cmp_full",  32'(bus.status_full),  32'(m_q.size() == M));
            check("cmp_half",  32'(bus.half_full),    32'(m_q.size() >= M / 2));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            check("cmp_overflow",  32'(bus.overflow),  32'(m_ovf));
            check("cmp_underflow", 32'(bus.underflow), 32'(m_unf));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic w, input logic r, input logic [N-1:0] d);
        @(negedge clk);
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;

        // 1. reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("rst_data_out", 32'(bus.data_out), 32'h0);
        check("rst_empty", 32'(bus.status_empty), 32'h1);
        check("rst_full",  32'(bus.status_full),  32'h0);
        check("rst_half",  32'(bus.half_full),    32'h0);

        // 2. fill
        step(1, 0, 8'h01);
        check("fill1_empty", 32'(bus.status_empty), 32'h0);
        check("fill1_half",  32'(bus.half_full),    32'h0);
        step(1, 0, 8'h02);
        check("fill2_half",  32'(bus.half_full),    32'h1);
        step(1, 0, 8'h03);
        check("fill3_full",  32'(bus.status_full),  32'h0);
        step(1, 0, 8'h04);
        check("fill4_full",  32'(bus.status_full),  32'h1);
        step(1, 0, 8'h05);
        check("drop_full",   32'(bus.status_full),  32'h1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("overflow_set", 32'(bus.overflow), 32'h1);
`endif

        // 3. drain
        step(0, 1, 8'h00); check("drain1", 32'(bus.data_out), 32'h01);
        step(0, 1, 8'h00); check("drain2", 32'(bus.data_out), 32'h02);
        step(0, 1, 8'h00); check("drain3", 32'(bus.data_out), 32'h03);
        step(0, 1, 8'h00); check("drain4", 32'(bus.data_out), 32'h04);
        check("drain_empty", 32'(bus.status_empty), 32'h1);
        step(0, 1, 8'h00); check("drain5_hold", 32'(bus.data_out), 32'h04);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("underflow_set", 32'(bus.underflow), 32'h1);
`endif

        // 4. concurrent at count=2
        step(1, 0, 8'h01);
        step(1, 0, 8'h02);
        step(1, 1, 8'h03);
        check("conc1_data", 32'(bus.data_out), 32'h01);
        check("conc1_half", 32'(bus.half_full), 32'h1);
        check("conc1_full", 32'(bus.status_full), 32'h0);
        step(1, 1, 8'h04);
        check("conc2_data", 32'(bus.data_out), 32'h02);
        check("conc2_half", 32'(bus.half_full), 32'h1);
        step(0, 1, 8'h00); check("conc_drain1", 32'(bus.data_out), 32'h03);
        step(0, 1, 8'h00); check("conc_drain2", 32'(bus.data_out), 32'h04);
        check("conc_empty", 32'(bus.status_empty), 32'h1);

        // 5. full concurrent, then drain across the pointer wrap
        for (int i = 1; i <= 4; i++) step(1, 0, 8'(i));
        check("fc_full_before", 32'(bus.status_full), 32'h1);
        step(1, 1, 8'h05);
        check("fc_data", 32'(bus.data_out), 32'h01);
        check("fc_full", 32'(bus.status_full), 32'h1);
        for (int i = 2; i <= 5; i++) begin
            step(0, 1, 8'h00);
            check("fc_drain", 32'(bus.data_out), 32'(i));
        end
        check("fc_empty", 32'(bus.status_empty), 32'h1);

        // 6. async reset mid-stream with count=3
        step(1, 0, 8'h11);
        step(1, 0, 8'h22);
        step(1, 0, 8'h33);
        check("pre_rst_half", 32'(bus.half_full), 32'h1);
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check("arst_empty", 32'(bus.status_empty), 32'h1);
        check("arst_data_out", 32'(bus.data_out), 32'h0);
        check("arst_full", 32'(bus.status_full), 32'h0);
        check("arst_half", 32'(bus.half_full), 32'h0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("arst_overflow",  32'(bus.overflow),  32'h0);
        check("arst_underflow", 32'(bus.underflow), 32'h0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;

        // post-reset sanity: contents were discarded, new data flows
        step(1, 0, 8'hAA);
        step(0, 1, 8'h00);
        check("post_rst_data", 32'(bus.data_out), 32'hAA);
        check("post_rst_empty", 32'(bus.status_empty), 32'h1);

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
